// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the team LFSR word stream: self-synchronises a local
// predictor from received data, then flywheels it and counts mismatches while locked.
module lfsr_sequence_checker #(
    parameter int N            = 16,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_W        = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_VALID,
    input  logic [N-1:0]     DATA_IN,
    input  logic             CLEAR_COUNT,
    output logic             LOCKED,
    output logic [1:0]       STATE,
    output logic             ERROR_PULSE,
    output logic [ERR_W-1:0] ERROR_COUNT
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int XW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Successor of w: rotate left, then fold the feedback bit into taps 1 and N-2.
    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] w);
        logic [N-1:0] r;
        r      = {w[N-2:0], w[N-1]};
        r[1]   = w[0] ^ w[N-1];
        r[N-2] = w[N-3] ^ w[N-1];
        return r;
    endfunction

    state_t           state_r;
    state_t           state_n_s;
    logic [N-1:0]     pred_r;
    logic [N-1:0]     pred_n_s;
    logic [MW-1:0]    match_cnt_r;
    logic [MW-1:0]    match_n_s;
    logic [MW-1:0]    match_inc_s;
    logic [XW-1:0]    miss_cnt_r;
    logic [XW-1:0]    miss_n_s;
    logic [XW-1:0]    miss_inc_s;
    logic             locked_r;
    logic             locked_n_s;
    logic             pulse_r;
    logic             pulse_n_s;
    logic [ERR_W-1:0] count_r;
    logic [ERR_W-1:0] count_n_s;
    logic             lock_miss_s;
    logic             data_zero_s;
    logic             data_hit_s;

    assign match_inc_s = match_cnt_r + MW'(1'b1);
    assign miss_inc_s  = miss_cnt_r + XW'(1'b1);
    assign data_zero_s = (DATA_IN == {N{1'b0}});
    assign data_hit_s  = (DATA_IN == pred_r);
    assign lock_miss_s = DATA_VALID && (state_r == ST_LOCKED) && !data_hit_s;

    // Next-state, predictor and counter logic.
    always_comb begin
        state_n_s = state_r;
        pred_n_s  = pred_r;
        match_n_s = match_cnt_r;
        miss_n_s  = miss_cnt_r;
        pulse_n_s = 1'b0;
        count_n_s = count_r;

        case (state_r)
            ST_SEARCH: begin
                if (DATA_VALID && !data_zero_s) begin
                    pred_n_s  = lfsr_next(DATA_IN);
                    match_n_s = {MW{1'b0}};
                    state_n_s = ST_SYNC;
                end else begin
                    state_n_s = ST_SEARCH;
                end
            end
            ST_SYNC: begin
                if (!DATA_VALID) begin
                    state_n_s = ST_SYNC;
                end else if (data_hit_s) begin
                    pred_n_s  = lfsr_next(DATA_IN);
                    match_n_s = match_inc_s;
                    if (match_inc_s == MW'(LOCK_COUNT)) begin
                        state_n_s = ST_LOCKED;
                        miss_n_s  = {XW{1'b0}};
                    end else begin
                        state_n_s = ST_SYNC;
                    end
                end else if (!data_zero_s) begin
                    pred_n_s  = lfsr_next(DATA_IN);
                    match_n_s = {MW{1'b0}};
                    state_n_s = ST_SYNC;
                end else begin
                    state_n_s = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (!DATA_VALID) begin
                    state_n_s = ST_LOCKED;
                end else if (data_hit_s) begin
                    pred_n_s = lfsr_next(pred_r);
                    miss_n_s = {XW{1'b0}};
                end else begin
                    // Flywheel regardless of the received word; data never reseeds here.
                    pred_n_s  = lfsr_next(pred_r);
                    pulse_n_s = 1'b1;
                    miss_n_s  = miss_inc_s;
                    if (miss_inc_s == XW'(UNLOCK_COUNT)) begin
                        state_n_s = ST_SEARCH;
                    end else begin
                        state_n_s = ST_LOCKED;
                    end
                end
            end
            default: begin
                state_n_s = ST_SEARCH;
                pred_n_s  = {N{1'b0}};
                match_n_s = {MW{1'b0}};
                miss_n_s  = {XW{1'b0}};
            end
        endcase

        // A clear coinciding with a locked mismatch keeps that one error.
        if (CLEAR_COUNT) begin
            count_n_s = lock_miss_s ? ERR_W'(1'b1) : {ERR_W{1'b0}};
        end else if (lock_miss_s && !(&count_r)) begin
            count_n_s = count_r + ERR_W'(1'b1);
        end else begin
            count_n_s = count_r;
        end

        locked_n_s = (state_n_s == ST_LOCKED);
    end

    // State, predictor, counter and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_SEARCH;
            pred_r      <= {N{1'b0}};
            match_cnt_r <= {MW{1'b0}};
            miss_cnt_r  <= {XW{1'b0}};
            locked_r    <= 1'b0;
            pulse_r     <= 1'b0;
            count_r     <= {ERR_W{1'b0}};
        end else begin
            state_r     <= state_n_s;
            pred_r      <= pred_n_s;
            match_cnt_r <= match_n_s;
            miss_cnt_r  <= miss_n_s;
            locked_r    <= locked_n_s;
            pulse_r     <= pulse_n_s;
            count_r     <= count_n_s;
        end
    end

    assign STATE       = state_r;
    assign LOCKED      = locked_r;
    assign ERROR_PULSE = pulse_r;
    assign ERROR_COUNT = count_r;

endmodule
